// File: rtl/kbd_pkg.sv
// Shared constants, FSM state encoding and FIFO entry layout for the keyboard event sequencer.
package kbd_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_LOOK,
        S_PUSH
    } state_t;

    // rpt marks a make of the key that is already held ("repeat" is reserved in SV)
    typedef struct packed {
        logic [7:0] scan;
        logic [7:0] ascii;
        logic       brk;
        logic       ext;
        logic       rpt;
    } evt_t;

endpackage

// File: rtl/kbd_evt_fifo.sv
// Synchronous FIFO of key events. A write while full is accepted only when
// a pop happens in the same cycle; an empty FIFO never bypasses a write to its output.
module kbd_evt_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_en,
    input  evt_t wr_data,
    output logic full,
    input  logic rd_en,
    output evt_t rd_data,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    evt_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_rd;
    logic          do_wr;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are only observable through the empty-gated read port.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_event_sequencer.sv
// PS/2 set-2 byte sequencer: strips E0/F0 prefixes, drives the external
// scancode->ASCII ROM, tracks the held key and press count, queues events.
// Optional build macro: KBD_SHIFT_EN (shift-key tracking, uppercases a..z).
//
// state  | meaning
// S_IDLE | waiting for first byte of a code
// S_EXT  | E0 seen, waiting for F0 or scancode
// S_BRK  | F0 seen, waiting for scancode
// S_LOOK | lut_code presented, ROM data settling
// S_PUSH | writing event into FIFO (stalls while full)
module kbd_event_sequencer
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ps2_valid,
    input  logic [7:0]       ps2_data,
    output logic             ps2_ready,
    output logic [7:0]       lut_code,
    input  logic [7:0]       lut_ascii,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_scan,
    output logic [7:0]       evt_ascii,
    output logic             evt_break,
    output logic             evt_ext,
    output logic             evt_repeat,
    output logic             key_held,
    output logic [CNT_W-1:0] press_cnt
);

    state_t     state;
    logic       ext_q;
    logic       brk_q;
    logic [8:0] held_id;
    logic [8:0] cur_id;
    logic       is_rpt;
    logic [7:0] ascii_v;
    logic       accept;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    evt_t       entry;
    evt_t       head;
`ifdef KBD_SHIFT_EN
    logic       shl_q;
    logic       shr_q;
`endif

    assign accept = ps2_valid & ps2_ready;
    assign pop    = evt_ready & ~fifo_empty;

    // Build the event for the code currently on lut_code; only meaningful in S_PUSH.
    always_comb begin
        cur_id  = {ext_q, lut_code};
        is_rpt  = ~brk_q & key_held & (cur_id == held_id);
        ascii_v = ext_q ? 8'h00 : lut_ascii;
`ifdef KBD_SHIFT_EN
        if ((shl_q | shr_q) && (ascii_v >= 8'h61) && (ascii_v <= 8'h7A))
            ascii_v = ascii_v - 8'h20;
`endif
        entry = '{scan: lut_code, ascii: ascii_v, brk: brk_q, ext: ext_q, rpt: is_rpt};
        push  = (state == S_PUSH) & (~fifo_full | pop);
    end

    // Prefix decode, lookup sequencing and held-key/press bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ps2_ready <= 1'b0;
            lut_code  <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            key_held  <= 1'b0;
            held_id   <= '0;
            press_cnt <= '0;
`ifdef KBD_SHIFT_EN
            shl_q     <= 1'b0;
            shr_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_EXT, S_BRK: begin
                    ps2_ready <= 1'b1;
                    if (accept) begin
                        if (ps2_data == PS2_EXT) begin
                            // a second E0, or E0 after F0, changes nothing
                            if (state == S_IDLE) begin
                                ext_q <= 1'b1;
                                state <= S_EXT;
                            end
                        end else if (ps2_data == PS2_BRK) begin
                            brk_q <= 1'b1;
                            state <= S_BRK;
                        end else begin
                            lut_code  <= ps2_data;
                            ps2_ready <= 1'b0;
                            state     <= S_LOOK;
                        end
                    end
                end
                S_LOOK: state <= S_PUSH;
                S_PUSH: begin
                    if (push) begin
                        if (!brk_q) begin
                            if (!is_rpt) begin
                                press_cnt <= press_cnt + CNT_W'(1);
                                held_id   <= cur_id;
                                key_held  <= 1'b1;
                            end
                        end else if (key_held && (cur_id == held_id)) begin
                            key_held <= 1'b0;
                        end
`ifdef KBD_SHIFT_EN
                        if (!ext_q && (lut_code == SC_LSHIFT)) shl_q <= ~brk_q;
                        if (!ext_q && (lut_code == SC_RSHIFT)) shr_q <= ~brk_q;
`endif
                        ext_q     <= 1'b0;
                        brk_q     <= 1'b0;
                        ps2_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    ps2_ready <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    kbd_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (entry),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty)
    );

    assign evt_valid  = ~fifo_empty;
    assign evt_scan   = head.scan;
    assign evt_ascii  = head.ascii;
    assign evt_break  = head.brk;
    assign evt_ext    = head.ext;
    assign evt_repeat = head.rpt;

endmodule

// File: tb/tb_kbd_event_sequencer.sv
// Randomized bench for kbd_event_sequencer with a byte-stream reference model.
module tb_kbd_event_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_valid = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_ready;
    logic [7:0] lut_code;
    logic [7:0] lut_ascii = 8'h00;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [7:0] evt_scan;
    logic [7:0] evt_ascii;
    logic       evt_break;
    logic       evt_ext;
    logic       evt_repeat;
    logic       key_held;
    logic [7:0] press_cnt;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;

    kbd_event_sequencer #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_valid  (ps2_valid),
        .ps2_data   (ps2_data),
        .ps2_ready  (ps2_ready),
        .lut_code   (lut_code),
        .lut_ascii  (lut_ascii),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_scan   (evt_scan),
        .evt_ascii  (evt_ascii),
        .evt_break  (evt_break),
        .evt_ext    (evt_ext),
        .evt_repeat (evt_repeat),
        .key_held   (key_held),
        .press_cnt  (press_cnt)
    );

    // external lookup ROM: one-cycle registered read
    function automatic logic [7:0] rom(input logic [7:0] c);
        case (c)
            8'h15:   return 8'h71;
            8'h1C:   return 8'h61;
            8'h1D:   return 8'h77;
            8'h24:   return 8'h65;
            8'h2D:   return 8'h72;
            8'h2C:   return 8'h74;
            8'h12:   return 8'h00;
            8'h59:   return 8'h00;
            8'h75:   return 8'h38;
            default: return c ^ 8'h55;
        endcase
    endfunction

    always @(posedge clk) lut_ascii <= rom(lut_code);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: interprets the byte stream directly
    logic        m_ext, m_brk, m_held, m_shl, m_shr;
    logic [8:0]  m_hid;
    logic [7:0]  m_cnt;
    logic [18:0] exp_q[$];

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held = 0; m_shl = 0; m_shr = 0;
        m_hid = '0; m_cnt = '0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [8:0] id;
        logic [7:0] asc;
        logic       rep;
        if (b == 8'hE0) begin
            if (!m_brk) m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            id  = {m_ext, b};
            asc = m_ext ? 8'h00 : rom(b);
`ifdef KBD_SHIFT_EN
            if ((m_shl || m_shr) && asc >= 8'h61 && asc <= 8'h7A) asc = asc - 8'h20;
            if (!m_ext && b == 8'h12) m_shl = !m_brk;
            if (!m_ext && b == 8'h59) m_shr = !m_brk;
`endif
            rep = !m_brk && m_held && (id == m_hid);
            if (!m_brk && !rep) begin
                m_cnt  = m_cnt + 8'd1;
                m_hid  = id;
                m_held = 1;
            end else if (m_brk && m_held && id == m_hid) begin
                m_held = 0;
            end
            exp_q.push_back({b, asc, m_brk, m_ext, rep});
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // consumer: choose ready for the coming edge, then check the head it will pop
    logic [18:0] cons_e;
    always @(negedge clk) begin
        if (rand_ready) evt_ready = ($urandom_range(0, 3) != 0);
        if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("evt_unexpected", 32'd1, 32'd0);
            end else begin
                cons_e = exp_q.pop_front();
                chk("evt", {evt_scan, evt_ascii, evt_break, evt_ext, evt_repeat}, cons_e);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        ps2_valid = 1'b1;
        ps2_data  = b;
        while (!ps2_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ps2_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            ps2_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_byte(b);
        #1 ps2_valid = 1'b0;
    endtask

    task automatic hold_ready(input logic v);
        @(posedge clk);
        #1;
        rand_ready = 1'b0;
        evt_ready  = v;
    endtask

    task automatic drain();
        int n = 0;
        rand_ready = 1'b1;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", (exp_q.size() == 0), 32'd1);
        repeat (4) @(negedge clk);
        chk("press_cnt", press_cnt, m_cnt);
        chk("key_held", key_held, m_held);
        if (!evt_valid)
            chk("empty_fields", {evt_scan, evt_ascii, evt_break, evt_ext, evt_repeat}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] b;
        logic [7:0] pool [8];
        pool[0] = 8'h15; pool[1] = 8'h1C; pool[2] = 8'h1D; pool[3] = 8'h24;
        pool[4] = 8'h12; pool[5] = 8'h59; pool[6] = 8'h75; pool[7] = 8'h2C;

        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", ps2_ready, 32'd0);
        chk("rst_valid", evt_valid, 32'd0);
        chk("rst_cnt", press_cnt, 32'd0);
        chk("rst_held", key_held, 32'd0);
        chk("rst_code", lut_code, 32'd0);
        rst_n = 1'b1;

        // single make: latency and contents
        send_byte(8'h15);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!evt_valid && lat < 10);
        chk("latency", lat, 32'd3);
        chk("first_scan", evt_scan, 32'h15);
        chk("first_ascii", evt_ascii, 32'h71);
        chk("first_cnt", press_cnt, 32'd1);
        chk("first_held", key_held, 32'd1);
        drain();

        // release of held key
        send_byte(8'hF0); send_byte(8'h15);
        drain();
        chk("brk_cnt", press_cnt, 32'd1);
        chk("brk_held", key_held, 32'd0);

        // repeats
        send_byte(8'h15); send_byte(8'h15); send_byte(8'h15);
        drain();
        chk("rep_cnt", press_cnt, 32'd2);

        // extended break, double E0
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h75);
        drain();

        // full FIFO stall, single pop releases the fifth event
        hold_ready(1'b0);
        send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24);
        send_byte(8'h2D); send_byte(8'h2C);
        repeat (6) @(negedge clk);
        chk("stall_ready", ps2_ready, 32'd0);
        chk("stall_valid", evt_valid, 32'd1);
        hold_ready(1'b1);
        hold_ready(1'b0);
        repeat (4) @(negedge clk);
        chk("unstall_ready", ps2_ready, 32'd1);
        drain();

        // shift then letter
        send_byte(8'h12); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h12);
        drain();

        // reset while lookup in flight
        send_byte(8'h15);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_look_valid", evt_valid, 32'd0);
        chk("rst_look_cnt", press_cnt, 32'd0);
        chk("rst_look_held", key_held, 32'd0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 12)      b = 8'hE0;
            else if (r < 27) b = 8'hF0;
            else if (r < 92) b = pool[$urandom_range(0, 7)];
            else             b = 8'($urandom_range(0, 255));
            send_byte(b);
            if (i % 75 == 74) drain();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
